// File: rtl/ami_req_merge.sv
// ami_req_merge: merges two AMI request ports onto one memory port and steers read responses back in order.
// Defining AMI_MERGE_STATS_EN builds the rd/wr/stall statistics counters; otherwise the stat ports read 0.

package ami_pkg;

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
    logic [2:0]  size;
  } AMIRequest;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } AMIResponse;

endpackage

// ami_tag_fifo: records the requesting port of each outstanding read, oldest at the head.
// Latency: a pushed entry reaches the head one cycle after the push.
// Backpressure: a push is taken when not full, or when full and a pop happens in the same cycle.
module ami_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld,
  input  logic [W-1:0]          push_dat,
  input  logic                  pop_vld,
  output logic [W-1:0]          head_dat,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop_vld & ~empty;
  assign do_push  = push_vld & (~full | do_pop);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// ami_req_merge: round-robin merge of two request ports into one registered output request.
// Latency: 1 cycle from in_req_grants to out_req.valid; responses pass through combinationally.
// Backpressure: output register reloads only when empty or handshaking; reads also need tag FIFO room.
module ami_req_merge #(
  parameter int TAG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  ami_pkg::AMIRequest [1:0]      in_reqs,
  output logic [1:0]                    in_req_grants,
  output ami_pkg::AMIResponse [1:0]     in_resps,
  input  logic [1:0]                    in_resp_grants,
  output ami_pkg::AMIRequest            out_req,
  input  logic                          out_req_grant,
  input  ami_pkg::AMIResponse           out_resp,
  output logic                          out_resp_grant,
  output logic [$clog2(TAG_DEPTH):0]    pending,
  output logic                          orphan_err,
  output logic [31:0]                   stat_rd,
  output logic [31:0]                   stat_wr,
  output logic [31:0]                   stat_stall
);

  ami_pkg::AMIRequest out_req_q, out_req_d;
  ami_pkg::AMIRequest acc_req;
  logic               last_q, last_d;
  logic               orphan_q, orphan_d;
  logic [1:0]         elig;
  logic               win;
  logic               acc_vld;
  logic               rd_push;
  logic               loadable;
  logic               tag_full, tag_empty, tag_head;
  logic               tag_room;
  logic               resp_pop;

  assign loadable = ~out_req_q.valid | out_req_grant;
  assign resp_pop = rst & ~tag_empty & out_resp.valid & in_resp_grants[tag_head];
  // A full FIFO still takes a new read when the head is retiring this same cycle.
  assign tag_room = ~tag_full | resp_pop;

  always_comb begin
    elig = '0;
    for (int p = 0; p < 2; p++) begin
      elig[p] = rst & in_reqs[p].valid & loadable & (in_reqs[p].isWrite | tag_room);
    end
  end

  always_comb begin
    in_req_grants = '0;
    if (elig[0] && elig[1]) win = ~last_q;
    else                    win = elig[1];
    if (|elig) in_req_grants[win] = 1'b1;
  end

  assign acc_vld = |elig;
  assign acc_req = in_reqs[win];
  assign rd_push = acc_vld & ~acc_req.isWrite;

  always_comb begin
    out_req_d = out_req_q;
    last_d    = last_q;
    orphan_d  = orphan_q | (tag_empty & out_resp.valid);
    if (acc_vld) begin
      out_req_d = acc_req;
      last_d    = win;
    end else if (out_req_grant) begin
      out_req_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_req_q <= '0;
      last_q    <= 1'b1;
      orphan_q  <= 1'b0;
    end else begin
      out_req_q <= out_req_d;
      last_q    <= last_d;
      orphan_q  <= orphan_d;
    end
  end

  ami_tag_fifo #(
    .W     (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (rd_push),
    .push_dat (win),
    .pop_vld  (resp_pop),
    .head_dat (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (pending)
  );

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_resps[p]       = out_resp;
      in_resps[p].valid = rst & out_resp.valid & ~tag_empty & (tag_head == 1'(p));
    end
    out_resp_grant = rst & ~tag_empty & in_resp_grants[tag_head];
  end

  assign out_req    = out_req_q;
  assign orphan_err = orphan_q;

`ifdef AMI_MERGE_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_rd_d    = stat_rd_q;
    stat_wr_d    = stat_wr_q;
    stat_stall_d = stat_stall_q;
    if (rd_push && stat_rd_q != '1)                   stat_rd_d    = stat_rd_q + 32'd1;
    if (acc_vld && acc_req.isWrite && stat_wr_q != '1) stat_wr_d    = stat_wr_q + 32'd1;
    if (out_req_q.valid && !out_req_grant && stat_stall_q != '1)
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_rd    = '0;
  assign stat_wr    = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_ami_req_merge.sv
// Directed bench for ami_req_merge (TAG_DEPTH=4); a negedge monitor checks outputs against scoreboard queues.
module tb_ami_req_merge;
  import ami_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  AMIRequest  [1:0]  in_reqs;
  logic       [1:0]  in_req_grants;
  AMIResponse [1:0]  in_resps;
  logic       [1:0]  in_resp_grants;
  AMIRequest         out_req;
  logic              out_req_grant;
  AMIResponse        out_resp;
  logic              out_resp_grant;
  logic       [2:0]  pending;
  logic              orphan_err;
  logic       [31:0] stat_rd, stat_wr, stat_stall;

  ami_req_merge #(.TAG_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_reqs        (in_reqs),
    .in_req_grants  (in_req_grants),
    .in_resps       (in_resps),
    .in_resp_grants (in_resp_grants),
    .out_req        (out_req),
    .out_req_grant  (out_req_grant),
    .out_resp       (out_resp),
    .out_resp_grant (out_resp_grant),
    .pending        (pending),
    .orphan_err     (orphan_err),
    .stat_rd        (stat_rd),
    .stat_wr        (stat_wr),
    .stat_stall     (stat_stall)
  );

  int tests = 0;
  int fails = 0;

  AMIRequest   exp_req_q[$];
  logic [64:0] exp_resp_q[$];
  AMIRequest   e_req;
  logic [64:0] e_resp;

`ifdef AMI_MERGE_STATS_EN
  localparam logic [63:0] EXP_STALL = 64'd5;
  localparam logic [63:0] EXP_RD    = 64'd7;
  localparam logic [63:0] EXP_WR    = 64'd2;
`else
  localparam logic [63:0] EXP_STALL = 64'd0;
  localparam logic [63:0] EXP_RD    = 64'd0;
  localparam logic [63:0] EXP_WR    = 64'd0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic AMIRequest mk(input logic wr, input logic [31:0] a, input logic [63:0] d);
    mk         = '0;
    mk.valid   = 1'b1;
    mk.isWrite = wr;
    mk.addr    = a;
    mk.data    = d;
    mk.size    = 3'd3;
  endfunction

  function automatic AMIResponse mkr(input logic [63:0] d);
    mkr       = '0;
    mkr.valid = 1'b1;
    mkr.data  = d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT completes a handshake.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_req.valid && out_req_grant) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_out_req", 64'(out_req.valid), 64'd0);
        end else begin
          e_req = exp_req_q.pop_front();
          chk("out_req_addr", 64'(out_req.addr), 64'(e_req.addr));
          chk("out_req_iswr", 64'(out_req.isWrite), 64'(e_req.isWrite));
          chk("out_req_data", out_req.data, e_req.data);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (in_resps[p].valid && in_resp_grants[p]) begin
          if (exp_resp_q.size() == 0) begin
            chk("unexpected_resp", 64'(in_resps[p].valid), 64'd0);
          end else begin
            e_resp = exp_resp_q.pop_front();
            chk("resp_port", 64'(p), 64'(e_resp[64]));
            chk("resp_data", in_resps[p].data, e_resp[63:0]);
            chk("resp_other_quiet", 64'(in_resps[p ^ 1].valid), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    in_reqs        = '0;
    in_resp_grants = 2'b11;
    out_req_grant  = 1'b1;
    out_resp       = '0;
    #2;
    in_reqs[0] = mk(1'b0, 32'h10, 64'h0);
    out_resp   = mkr(64'hDEAD);
    #1;
    chk("rst_out_vld", 64'(out_req.valid), 64'd0);
    chk("rst_out_payload", 64'(out_req.addr), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);
    chk("rst_grants", 64'(in_req_grants), 64'd0);
    chk("rst_resp_vld", 64'({in_resps[1].valid, in_resps[0].valid}), 64'd0);
    chk("rst_stat_rd", 64'(stat_rd), 64'd0);
    in_reqs  = '0;
    out_resp = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Both ports stream reads: grants alternate starting with port 0.
    for (int k = 0; k < 4; k++) begin
      in_reqs[0] = mk(1'b0, 32'h100 + 32'(k), 64'(k));
      in_reqs[1] = mk(1'b0, 32'h200 + 32'(k), 64'(k + 16));
      exp_req_q.push_back((k % 2 == 1) ? in_reqs[1] : in_reqs[0]);
      @(negedge clk);
      chk("rr_grant", 64'(in_req_grants), (k % 2 == 1) ? 64'd2 : 64'd1);
      if (k > 0) chk("rr_out_vld", 64'(out_req.valid), 64'd1);
      tick();
    end

    // FIFO full: reads blocked, a write still passes, push+pop keeps pending at 4.
    in_reqs[0] = mk(1'b0, 32'h110, 64'h11);
    in_reqs[1] = '0;
    @(negedge clk);
    chk("full_pending", 64'(pending), 64'd4);
    chk("full_rd_blocked", 64'(in_req_grants), 64'd0);
    tick();
    in_reqs[1] = mk(1'b1, 32'h210, 64'hAA);
    exp_req_q.push_back(in_reqs[1]);
    @(negedge clk);
    chk("full_wr_pass", 64'(in_req_grants), 64'd2);
    tick();
    in_reqs[1] = '0;
    out_resp   = mkr(64'hD0);
    exp_resp_q.push_back({1'b0, 64'hD0});
    exp_req_q.push_back(in_reqs[0]);
    @(negedge clk);
    chk("full_push_pop_grant", 64'(in_req_grants), 64'd1);
    tick();
    in_reqs  = '0;
    out_resp = mkr(64'hD1);
    exp_resp_q.push_back({1'b1, 64'hD1});
    @(negedge clk);
    chk("full_push_pop_pending", 64'(pending), 64'd4);
    tick();
    out_resp = mkr(64'hD2);
    exp_resp_q.push_back({1'b0, 64'hD2});
    tick();
    out_resp = mkr(64'hD3);
    exp_resp_q.push_back({1'b1, 64'hD3});
    tick();
    out_resp = mkr(64'hD4);
    exp_resp_q.push_back({1'b0, 64'hD4});
    tick();
    out_resp = '0;
    @(negedge clk);
    chk("drained_pending", 64'(pending), 64'd0);
    tick();

    // Port 0 read 0x40 then port 1 read 0x80; responses steered in order.
    in_reqs[0] = mk(1'b0, 32'h40, 64'h0);
    exp_req_q.push_back(in_reqs[0]);
    @(negedge clk);
    chk("steer_grant0", 64'(in_req_grants), 64'd1);
    tick();
    in_reqs[0] = '0;
    in_reqs[1] = mk(1'b0, 32'h80, 64'h0);
    exp_req_q.push_back(in_reqs[1]);
    @(negedge clk);
    chk("steer_grant1", 64'(in_req_grants), 64'd2);
    tick();
    in_reqs  = '0;
    out_resp = mkr(64'h1111);
    exp_resp_q.push_back({1'b0, 64'h1111});
    tick();
    out_resp = mkr(64'h2222);
    exp_resp_q.push_back({1'b1, 64'h2222});
    tick();
    out_resp = '0;

    // Output stalled for 5 cycles.
    in_reqs[0]    = mk(1'b1, 32'h300, 64'h3333);
    out_req_grant = 1'b0;
    exp_req_q.push_back(in_reqs[0]);
    @(negedge clk);
    chk("stall_first_grant", 64'(in_req_grants), 64'd1);
    tick();
    in_reqs[0] = '0;
    in_reqs[1] = mk(1'b1, 32'h304, 64'h4444);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_grant", 64'(in_req_grants), 64'd0);
      chk("stall_addr_stable", 64'(out_req.addr), 64'h300);
      chk("stall_data_stable", out_req.data, 64'h3333);
      tick();
    end
    out_req_grant = 1'b1;
    exp_req_q.push_back(in_reqs[1]);
    @(negedge clk);
    chk("stat_stall", 64'(stat_stall), EXP_STALL);
    chk("stat_rd", 64'(stat_rd), EXP_RD);
    chk("stat_wr", 64'(stat_wr), EXP_WR);
    chk("stall_release_grant", 64'(in_req_grants), 64'd2);
    tick();
    in_reqs = '0;
    tick();

    // Response with nothing outstanding.
    out_resp = mkr(64'h5555);
    @(negedge clk);
    chk("orphan_no_grant", 64'(out_resp_grant), 64'd0);
    chk("orphan_pending", 64'(pending), 64'd0);
    tick();
    out_resp = '0;
    @(negedge clk);
    chk("orphan_set", 64'(orphan_err), 64'd1);
    tick();
    tick();
    @(negedge clk);
    chk("orphan_sticky", 64'(orphan_err), 64'd1);
    tick();

    // Three reads outstanding, then asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      in_reqs[0] = mk(1'b0, 32'h500 + 32'(k), 64'h0);
      exp_req_q.push_back(in_reqs[0]);
      tick();
    end
    in_reqs       = '0;
    out_req_grant = 1'b0;
    #1;
    chk("pre_rst_pending", 64'(pending), 64'd3);
    chk("pre_rst_out_vld", 64'(out_req.valid), 64'd1);
    exp_req_q.delete();
    in_reqs[0] = mk(1'b0, 32'h5F0, 64'h0);
    in_reqs[1] = mk(1'b1, 32'h5F4, 64'h0);
    out_resp   = mkr(64'h6666);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_pending", 64'(pending), 64'd0);
    chk("async_rst_out_vld", 64'(out_req.valid), 64'd0);
    chk("async_rst_grants", 64'(in_req_grants), 64'd0);
    chk("async_rst_resp_vld", 64'({in_resps[1].valid, in_resps[0].valid}), 64'd0);
    chk("async_rst_orphan", 64'(orphan_err), 64'd0);
    @(negedge clk);
    chk("rst_hold_pending", 64'(pending), 64'd0);
    in_reqs[0]    = mk(1'b1, 32'h600, 64'h66);
    in_reqs[1]    = mk(1'b1, 32'h700, 64'h77);
    out_resp      = '0;
    out_req_grant = 1'b1;
    rst           = 1'b1;
    #1;
    chk("post_rst_port0_first", 64'(in_req_grants), 64'd1);
    exp_req_q.push_back(in_reqs[0]);
    tick();
    exp_req_q.push_back(in_reqs[1]);
    @(negedge clk);
    chk("post_rst_port1_next", 64'(in_req_grants), 64'd2);
    tick();
    in_reqs = '0;

    for (int i = 0; i < 20; i++) begin
      if (exp_req_q.size() == 0 && exp_resp_q.size() == 0) break;
      tick();
    end
    chk("drain_req_queue", 64'(exp_req_q.size()), 64'd0);
    chk("drain_resp_queue", 64'(exp_resp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ami_req_merge.md
AMI_REQ_MERGE -- requirements
Module: ami_req_merge

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 16, power of 2 >= 2: read-tag FIFO depth, i.e. the maximum number of outstanding reads.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_reqs[1:0]  input  AMIRequest  upstream request ports 0/1.
REQ-005 SHALL have port in_req_grants[1:0]  output  1 each  upstream request accepted this cycle.
REQ-006 SHALL have port in_resps[1:0]  output  AMIResponse  responses steered back to ports 0/1.
REQ-007 SHALL have port in_resp_grants[1:0]  input  1 each  upstream response consumed.
REQ-008 SHALL have port out_req  output  AMIRequest  merged request to memory.
REQ-009 SHALL have port out_req_grant  input  1  memory accepted out_req.
REQ-010 SHALL have port out_resp  input  AMIResponse  memory read response.
REQ-011 SHALL have port out_resp_grant  output  1  response consumed.
REQ-012 SHALL have port pending  output  log2(TAG_DEPTH)+1  outstanding read count.
REQ-013 SHALL have port orphan_err  output  1  sticky: a response arrived with no outstanding read.
REQ-014 SHALL have ports stat_rd, stat_wr, stat_stall  output  32 each  statistics counters (see REQ-030).

Function
REQ-015 SHALL hold out_req in a single output register; out_req.valid stays high and the payload stays stable until out_req_grant=1.
REQ-016 SHALL treat the register as loadable when it is empty, or when out_req.valid & out_req_grant in the same cycle (back-to-back, no bubble).
REQ-017 SHALL accept port p (in_req_grants[p]=1) only when in_reqs[p].valid, the register is loadable, p wins arbitration, and the request is a write or the tag FIFO is not full; at most one grant per cycle.
REQ-018 SHALL arbitrate round-robin: if both ports are eligible, the port not granted most recently wins; the last-winner pointer updates only on an actual grant and resets to 1 (port 0 wins first).
REQ-019 SHALL make a read that is blocked only by a full FIFO ineligible, so an eligible write on the other port proceeds in that cycle.
REQ-020 SHALL register the accepted request unmodified (valid, isWrite, addr, data, size), with latency 1 cycle from grant to out_req.valid.
REQ-021 SHALL push the port id into the tag FIFO on each accepted read; writes produce no response and push nothing.
REQ-022 SHALL, when the FIFO is not empty, drive in_resps[head] = out_resp with the other port's valid forced to 0, and out_resp_grant = in_resp_grants[head]; pop when out_resp.valid & out_resp_grant.
REQ-023 SHALL hold out_resp_grant=0 when the FIFO is empty, and set orphan_err if out_resp.valid=1 in that state.
REQ-024 SHALL support push and pop in the same cycle (pending unchanged), including when full; pending = pushes minus pops, range 0..TAG_DEPTH.
REQ-025 SHALL wrap the FIFO read/write pointers modulo TAG_DEPTH.
REQ-026 SHALL keep in_req_grants, in_resps and out_resp_grant combinational from current inputs and state; out_req is registered only.

Reset
REQ-027 SHALL, on rst=0 (asynchronous, mid-transfer included), clear: out_req.valid=0, payload=0, FIFO empty, pending=0, orphan_err=0, last-winner=1, all stat counters=0.
REQ-028 SHALL drive all grants and in_resps[*].valid to 0 while rst=0; any in-flight reads are discarded.
REQ-029 SHALL resume normal operation on the first clock edge after rst deasserts.

Configuration
REQ-030 SHALL, when macro AMI_MERGE_STATS_EN is defined, count accepted reads (stat_rd), accepted writes (stat_wr), and cycles with out_req.valid & !out_req_grant (stat_stall); the counters saturate at 0xFFFFFFFF.
REQ-031 SHALL, without AMI_MERGE_STATS_EN, keep the stat ports present, tie them to 0, and implement no counter flops.

Verification
REQ-032 SHALL: both ports issue continuous reads, out_req_grant=1 -> grants alternate 0,1,0,1; out_req.valid every cycle after the first.
REQ-033 SHALL: port0 read addr 0x40 then port1 read addr 0x80; memory returns 2 responses -> the first appears only on in_resps[0], the second only on in_resps[1].
REQ-034 SHALL: TAG_DEPTH=4, 4 reads with no responses -> pending=4, further reads not granted; a concurrent port1 write is granted; 1 response plus 1 new read in the same cycle -> pending stays 4.
REQ-035 SHALL: out_req_grant held 0 for 5 cycles -> out_req is stable, no grants, stat_stall=5 (macro on) / 0 (macro off).
REQ-036 SHALL: out_resp.valid with pending=0 -> out_resp_grant=0 and orphan_err=1, held until reset.
REQ-037 SHALL: rst asserted with 3 reads pending -> pending=0 and out_req.valid=0 immediately, without waiting for a clock edge.
